muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer beside the single-cycle ALU in the EX stage.
- Executes MULT, MULTU, DIV and DIVU iteratively and owns the architectural HI/LO registers.
- Exposes busy/ready so hazard logic can stall EX. Takes MTHI/MTLO writes and drives MFHI/MFLO read data.

Parameters:
- bNUM, 32, operand width; HI and LO are each bNUM bits.
- bCNT, 6, iteration counter width; must satisfy 2^bCNT > bNUM.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request a new operation; accepted only when ready=1.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  in  bNUM  rs operand (multiplicand / dividend).
- B  in  bNUM  rt operand (multiplier / divisor).
- flush  in  1  synchronous abort of an in-flight operation.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  bNUM  MTHI/MTLO data.
- ready  out  1  idle, can accept start.
- busy  out  1  operation in flight (= ~ready).
- done  out  1  one-cycle pulse when HI/LO are updated with a result.
- HI  out  bNUM  HI register.
- LO  out  bNUM  LO register.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; HI=0, LO=0, done=0, ready=1, busy=0.
  - All internal accumulators, counter and sign flags cleared.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: on start&ready at an edge, latch op, the operand magnitudes (signed ops take the absolute value, unsigned ops pass through) and the result signs; counter=0; go to CALC.
- CALC: exactly bNUM cycles, one radix-2 step per cycle, counter increments. Go to FIX when counter reaches bNUM-1.
- Multiply step:
  - 2*bNUM accumulator += shifted multiplicand when multiplier LSB=1.
  - Multiplicand shifts left, multiplier shifts right.
- Divide step:
  - Restoring division: remainder shifts left with the next dividend bit.
  - Subtract divisor if no borrow, quotient bit = ~borrow.
- FIX (1 cycle): apply sign correction.
  - MULT: negate the 2*bNUM product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- DONE (1 cycle): done=1, HI/LO written at the entry edge.
  - Multiply: HI = product upper half, LO = lower half.
  - Divide: HI = remainder, LO = quotient.
  - Return to IDLE next edge.
- Latency: accept edge to done=1 is bNUM+2 cycles (34 at default).
- ready=1 only in IDLE.
- start while busy is ignored; the requester holds start/op/A/B until it sees ready.
- Divide by zero (B=0, DIV or DIVU): LO={bNUM{1}}, HI=A (raw operand), normal latency, no trap.
- DIV overflow (-2^(bNUM-1) / -1): LO=0x80000000, HI=0 (magnitude arithmetic wraps); no flag.
- All arithmetic is modulo width; no saturation.
- flush while in CALC/FIX/DONE:
  - Next edge goes to IDLE, done suppressed.
  - HI/LO keep their values from before the operation (if already written in DONE, they keep the new values).
  - flush in IDLE has no effect. flush together with start in IDLE: start is accepted.
- hi_we/lo_we:
  - Honoured only when ready=1; dropped while busy (hazard logic must stall MTHI/MTLO on busy).
  - Simultaneous with start in IDLE: the write takes effect this edge; the later result overwrites it.
- reset_n low mid-operation aborts immediately to the reset state.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined:
  - MULT/MULTU leave CALC as soon as the remaining multiplier register is 0, minimum 1 CALC cycle.
  - Multiply latency = 2 + max(1, position of highest set bit of |B| + 1).
  - Divide latency is unchanged.
- Undefined: fixed bNUM CALC cycles for all ops.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - FSM state encoding.
  - Divide-by-zero LO constant.
- One natural sub-module: muldiv_step, the combinational single-iteration datapath (multiply add/shift or restore-subtract), instanced once inside CALC.

Test Plan:
- Reset: pulse reset_n low mid-CALC -> HI=0, LO=0, ready=1 immediately (async), no done pulse.
- MULT A=0xFFFFFFFD (-3), B=5 -> done at accept+34 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=100.
- Back-to-back and busy behaviour: start held during busy -> ignored until ready, second op accepted on the cycle ready=1. lo_we with wdata=0x1234 while busy -> LO unchanged; the same write when idle -> LO=0x1234 next edge.
- flush at CALC cycle 10 after MTHI=0xAA -> ready next edge, done never pulses, HI stays 0xAA.
- With MULDIV_EARLY_TERM_EN: MULTU A=7, B=3 -> done at accept+4, LO=21, HI=0. Without the macro, the same op -> done at accept+34.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// operation encodings, FSM state encoding and the divide-by-zero fill value.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Every bit of LO is filled with this value when a divide sees a zero divisor.
  localparam logic DIV0_LO_FILL = 1'b1;

  function automatic logic isDivOp(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic isSignedOp(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: acc accumulates the shifted multiplicand while the multiplier
// shifts right. Divide: acc holds {remainder, dividend/quotient}; each step
// shifts one dividend bit into the remainder and does a restoring subtract
// of the divisor held in the low half of mcand.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int bNUM = 32
) (
  input  logic              isDiv,
  input  logic [2*bNUM-1:0] acc,
  input  logic [2*bNUM-1:0] mcand,
  input  logic [bNUM-1:0]   mplier,
  output logic [2*bNUM-1:0] nextAcc,
  output logic [2*bNUM-1:0] nextMcand,
  output logic [bNUM-1:0]   nextMplier
);

  logic [bNUM-1:0] rem;
  logic [bNUM-1:0] dq;
  logic [bNUM-1:0] divisor;
  logic [bNUM:0]   trial;

  // Single iteration: add/shift for multiply, shift/trial-subtract for divide.
  always_comb begin
    nextAcc    = acc;
    nextMcand  = mcand;
    nextMplier = mplier;
    rem        = acc[2*bNUM-1:bNUM];
    dq         = acc[bNUM-1:0];
    divisor    = mcand[bNUM-1:0];
    trial      = {rem, dq[bNUM-1]} - {1'b0, divisor};
    if (isDiv) begin
      if (trial[bNUM]) begin
        nextAcc = {rem[bNUM-2:0], dq[bNUM-1], dq[bNUM-2:0], 1'b0};
      end else begin
        nextAcc = {trial[bNUM-1:0], dq[bNUM-2:0], 1'b1};
      end
    end else begin
      if (mplier[0]) begin
        nextAcc = acc + mcand;
      end
      nextMcand  = {mcand[2*bNUM-2:0], 1'b0};
      nextMplier = {1'b0, mplier[bNUM-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Works on operand magnitudes for bNUM iterations, fixes signs in one cycle,
// then writes HI/LO and pulses done. MTHI/MTLO writes are taken only while idle.
// Optional build macro MULDIV_EARLY_TERM_EN: multiplies leave the iteration
// phase as soon as the remaining multiplier is zero (at least one iteration).
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int bNUM = 32,
  parameter int bCNT = 6
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [bNUM-1:0] A,
  input  logic [bNUM-1:0] B,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [bNUM-1:0] wdata,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [bNUM-1:0] HI,
  output logic [bNUM-1:0] LO
);

  localparam logic [bCNT-1:0] LAST_CNT = bCNT'(bNUM - 1);

  state_e            state;
  op_e               opReg;
  logic [2*bNUM-1:0] accReg;
  logic [2*bNUM-1:0] mcandReg;
  // Holds the multiplier for multiplies and the raw dividend for divides.
  logic [bNUM-1:0]   mplierReg;
  logic [bCNT-1:0]   cnt;
  logic              negRes;
  logic              negRem;
  logic              divZero;

  op_e               opIn;
  logic              inSigned;
  logic              inDiv;
  logic [bNUM-1:0]   absA;
  logic [bNUM-1:0]   absB;
  logic              regIsDiv;
  logic              calcLast;
  logic [2*bNUM-1:0] stepAcc;
  logic [2*bNUM-1:0] stepMcand;
  logic [bNUM-1:0]   stepMplier;
  logic [2*bNUM-1:0] prodFixed;
  logic [bNUM-1:0]   quotMag;
  logic [bNUM-1:0]   remMag;
  logic [bNUM-1:0]   quotFixed;
  logic [bNUM-1:0]   remFixed;

  muldiv_step #(
    .bNUM(bNUM)
  ) u_step (
    .isDiv     (regIsDiv),
    .acc       (accReg),
    .mcand     (mcandReg),
    .mplier    (mplierReg),
    .nextAcc   (stepAcc),
    .nextMcand (stepMcand),
    .nextMplier(stepMplier)
  );

  // Decode the incoming request and take operand magnitudes for signed ops.
  always_comb begin
    opIn     = op_e'(op);
    inSigned = isSignedOp(opIn);
    inDiv    = isDivOp(opIn);
    absA     = (inSigned && A[bNUM-1]) ? -A : A;
    absB     = (inSigned && B[bNUM-1]) ? -B : B;
  end

  // Decide whether this iteration is the last one of the CALC phase.
  always_comb begin
    regIsDiv = isDivOp(opReg);
    calcLast = (cnt == LAST_CNT);
`ifdef MULDIV_EARLY_TERM_EN
    if (!regIsDiv && (stepMplier == '0)) begin
      calcLast = 1'b1;
    end
`endif
  end

  // Sign correction of the magnitude results, consumed in the FIX cycle.
  always_comb begin
    quotMag   = accReg[bNUM-1:0];
    remMag    = accReg[2*bNUM-1:bNUM];
    prodFixed = negRes ? -accReg : accReg;
    quotFixed = negRes ? -quotMag : quotMag;
    remFixed  = negRem ? -remMag : remMag;
  end

  // Sequencer FSM with registered ready/done and the architectural HI/LO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      opReg     <= OP_MULT;
      accReg    <= '0;
      mcandReg  <= '0;
      mplierReg <= '0;
      cnt       <= '0;
      negRes    <= 1'b0;
      negRem    <= 1'b0;
      divZero   <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      done      <= 1'b0;
      ready     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) begin
            HI <= wdata;
          end
          if (lo_we) begin
            LO <= wdata;
          end
          if (start) begin
            opReg   <= opIn;
            cnt     <= '0;
            negRes  <= inSigned && (A[bNUM-1] ^ B[bNUM-1]);
            negRem  <= inSigned && A[bNUM-1];
            divZero <= inDiv && (B == '0);
            if (inDiv) begin
              accReg    <= {{bNUM{1'b0}}, absA};
              mcandReg  <= {{bNUM{1'b0}}, absB};
              mplierReg <= A;
            end else begin
              accReg    <= '0;
              mcandReg  <= {{bNUM{1'b0}}, absA};
              mplierReg <= absB;
            end
            state <= S_CALC;
            ready <= 1'b0;
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end else begin
            accReg    <= stepAcc;
            mcandReg  <= stepMcand;
            mplierReg <= stepMplier;
            cnt       <= cnt + bCNT'(1);
            if (calcLast) begin
              state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end else begin
            if (!regIsDiv) begin
              HI <= prodFixed[2*bNUM-1:bNUM];
              LO <= prodFixed[bNUM-1:0];
            end else if (divZero) begin
              HI <= mplierReg;
              LO <= {bNUM{DIV0_LO_FILL}};
            end else begin
              HI <= remFixed;
              LO <= quotFixed;
            end
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign busy = ~ready;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic         flush   = 1'b0;
  logic         hi_we   = 1'b0;
  logic         lo_we   = 1'b0;
  logic [1:0]   op      = 2'b00;
  logic [W-1:0] A       = '0;
  logic [W-1:0] B       = '0;
  logic [W-1:0] wdata   = '0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int           checks = 0;
  int           errors = 0;
  int           curLat = 0;
  int           doneLat = 0;
  int           expLat = 0;
  logic [W-1:0] expHi = '0;
  logic [W-1:0] expLo = '0;

  muldiv_seq #(
    .bNUM(W),
    .bCNT(6)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .flush  (flush),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .HI     (HI),
    .LO     (LO)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Reference results from plain signed/unsigned arithmetic.
  function automatic void refModel(input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    hi = '0;
    lo = '0;
    case (o)
      2'b00: begin
        p  = sa * sb;
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b01: begin
        p  = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      default: begin
        if (b == '0) begin
          hi = a;
          lo = '1;
        end else if (o == 2'b10) begin
          q  = sa / sb;
          r  = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
    endcase
  endfunction

  // Expected accept-to-done cycle count.
  function automatic int refLatency(input logic [1:0] o, input logic [W-1:0] b);
    int           calc;
    logic [W-1:0] m;
    calc = W;
    m    = ((o == 2'b00) && b[W-1]) ? -b : b;
`ifdef MULDIV_EARLY_TERM_EN
    if (o[1] == 1'b0) begin
      calc = 1;
      for (int i = 0; i < W; i++) begin
        if (m[i]) calc = (i + 1 > 1) ? i + 1 : 1;
      end
    end
`endif
    return 2 + calc;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      @(negedge clock);
      curLat++;
      if (done === 1'b1 && doneLat == 0) doneLat = curLat;
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b, input string tag);
    refModel(o, a, b, expHi, expLo);
    expLat = refLatency(o, b);
    checkOutput({tag, "_ready_before"}, {63'b0, ready}, 64'd1);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clock);
    @(negedge clock);
    start   = 1'b0;
    curLat  = 1;
    doneLat = (done === 1'b1) ? 1 : 0;
  endtask

  task automatic awaitResult(input string tag);
    while (doneLat == 0 && curLat < 120) advance(1);
    checkOutput({tag, "_latency"}, 64'(doneLat), 64'(expLat));
    checkOutput({tag, "_hi"}, {32'b0, HI}, {32'b0, expHi});
    checkOutput({tag, "_lo"}, {32'b0, LO}, {32'b0, expLo});
    advance(1);
    checkOutput({tag, "_done_one_cycle"}, {63'b0, done}, 64'd0);
    checkOutput({tag, "_ready_after"}, {63'b0, ready}, 64'd1);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] savedLo;

    // Reset state
    @(negedge clock);
    checkOutput("reset_hi", {32'b0, HI}, 64'd0);
    checkOutput("reset_lo", {32'b0, LO}, 64'd0);
    checkOutput("reset_ready", {63'b0, ready}, 64'd1);
    checkOutput("reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("reset_done", {63'b0, done}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed arithmetic cases
    applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5, "mult");
    awaitResult("mult");
    checkOutput("mult_hi_const", {32'b0, HI}, 64'hFFFFFFFF);
    checkOutput("mult_lo_const", {32'b0, LO}, 64'hFFFFFFF1);
`ifndef MULDIV_EARLY_TERM_EN
    checkOutput("mult_latency_const", 64'(doneLat), 64'd34);
`endif
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'd2, "multu");
    awaitResult("multu");
    checkOutput("multu_hi_const", {32'b0, HI}, 64'h1);
    checkOutput("multu_lo_const", {32'b0, LO}, 64'hFFFFFFFE);
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, "div");
    awaitResult("div");
    checkOutput("div_hi_const", {32'b0, HI}, 64'hFFFFFFFF);
    checkOutput("div_lo_const", {32'b0, LO}, 64'hFFFFFFFD);
    applyStimulus(2'b11, 32'd100, 32'd0, "divu_zero");
    awaitResult("divu_zero");
    checkOutput("divu_zero_hi_const", {32'b0, HI}, 64'd100);
    checkOutput("divu_zero_lo_const", {32'b0, LO}, 64'hFFFFFFFF);
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd0, "div_zero_neg");
    awaitResult("div_zero_neg");
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    awaitResult("div_ovf");
    checkOutput("div_ovf_lo_const", {32'b0, LO}, 64'h80000000);
    checkOutput("div_ovf_hi_const", {32'b0, HI}, 64'h0);
    applyStimulus(2'b01, 32'd7, 32'd3, "multu_small");
    awaitResult("multu_small");
    checkOutput("multu_small_lo_const", {32'b0, LO}, 64'd21);
`ifdef MULDIV_EARLY_TERM_EN
    checkOutput("multu_small_latency_const", 64'(doneLat), 64'd4);
`else
    checkOutput("multu_small_latency_const", 64'(doneLat), 64'd34);
`endif

    // MTLO while idle lands on the next edge
    lo_we = 1'b1;
    wdata = 32'h1234;
    @(posedge clock);
    @(negedge clock);
    lo_we = 1'b0;
    checkOutput("mtlo_idle", {32'b0, LO}, 64'h1234);

    // MTHI/MTLO while busy are dropped
    applyStimulus(2'b11, 32'd1000, 32'd7, "busy_wr");
    advance(2);
    lo_we = 1'b1;
    hi_we = 1'b1;
    wdata = 32'h5555;
    advance(1);
    lo_we = 1'b0;
    hi_we = 1'b0;
    checkOutput("busy_wr_lo_kept", {32'b0, LO}, 64'h1234);
    checkOutput("busy_wr_busy", {63'b0, busy}, 64'd1);
    awaitResult("busy_wr");

    // Back-to-back: start held through busy, second op taken when ready rises
    applyStimulus(2'b00, 32'h12345678, 32'hFEDCBA98, "b2b_first");
    start = 1'b1;
    op    = 2'b10;
    A     = 32'hFFFF0000;
    B     = 32'd12345;
    awaitResult("b2b_first");
    applyStimulus(2'b10, 32'hFFFF0000, 32'd12345, "b2b_second");
    awaitResult("b2b_second");

    // Flush in CALC after an MTHI
    hi_we = 1'b1;
    wdata = 32'hAA;
    @(posedge clock);
    @(negedge clock);
    hi_we = 1'b0;
    savedLo = LO;
    applyStimulus(2'b11, 32'hDEADBEEF, 32'd3, "flush");
    advance(9);
    flush = 1'b1;
    advance(1);
    flush = 1'b0;
    checkOutput("flush_ready", {63'b0, ready}, 64'd1);
    advance(40);
    checkOutput("flush_no_done", 64'(doneLat), 64'd0);
    checkOutput("flush_hi_kept", {32'b0, HI}, 64'hAA);
    checkOutput("flush_lo_kept", {32'b0, LO}, {32'b0, savedLo});

    // flush together with start in IDLE: the start wins
    flush = 1'b1;
    applyStimulus(2'b01, 32'h0000FFFF, 32'h00010001, "flush_start");
    flush = 1'b0;
    checkOutput("flush_start_busy", {63'b0, busy}, 64'd1);
    awaitResult("flush_start");

    // Async reset in the middle of CALC
    applyStimulus(2'b11, 32'hCAFEF00D, 32'd9, "rst_mid");
    advance(5);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_hi", {32'b0, HI}, 64'd0);
    checkOutput("rst_mid_lo", {32'b0, LO}, 64'd0);
    checkOutput("rst_mid_ready", {63'b0, ready}, 64'd1);
    checkOutput("rst_mid_busy", {63'b0, busy}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    doneLat = 0;
    advance(40);
    checkOutput("rst_mid_no_done", 64'(doneLat), 64'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       ra = 32'h80000000;
        1:       ra = 32'($urandom_range(0, 15));
        2:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      applyStimulus(ro, ra, rb, $sformatf("rand%0d", i));
      awaitResult($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
